// File: rtl/upsizing.sv
// AXI-Stream width upsizer: packs pairs of W-bit beats into one 2W-bit word,
// first beat in the upper half; an odd tlast beat is flushed as a half word.
module upsizing #(
  parameter int W = 32
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [W-1:0]   in_tdata,
  input  logic           in_tvalid,
  input  logic           in_tlast,
  output logic           in_tready,
  output logic [2*W-1:0] out_tdata,
  output logic [1:0]     out_tkeep,
  output logic           out_tlast,
  output logic           out_tvalid,
  input  logic           out_tready
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high; valid never waits on ready, and a stalled output holds all fields.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FLUSH = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   hi_q;
  logic           half_valid, half_last;
  logic           out_free, in_fire;
  logic           hi_load, out_load;
  logic [2*W-1:0] load_data;
  logic [1:0]     load_keep;
  logic           load_last;

  assign half_valid = (state_q != EMPTY);
  assign half_last  = (state_q == FLUSH);
  assign out_free   = ~out_tvalid | out_tready;
  assign in_tready  = ~half_valid | (~half_last & out_free);
  assign in_fire    = in_tvalid & in_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_load   = 1'b0;
    out_load  = 1'b0;
    load_data = '0;
    load_keep = 2'b00;
    load_last = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          hi_load = 1'b1;
          state_d = in_tlast ? FLUSH : HALF;
        end
      end
      HALF: begin
        if (in_fire) begin
          out_load  = 1'b1;
          load_data = {hi_q, in_tdata};
          load_keep = 2'b11;
          load_last = in_tlast;
          state_d   = EMPTY;
        end
      end
      FLUSH: begin
        // Lone last beat goes out in the upper half; lower half is padding.
        if (out_free) begin
          out_load  = 1'b1;
          load_data = {hi_q, {W{1'b0}}};
          load_keep = 2'b10;
          load_last = 1'b1;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hi_q <= '0;
    end else if (hi_load) begin
      hi_q <= in_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_tdata  <= '0;
      out_tkeep  <= 2'b00;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
    end else if (out_load) begin
      out_tdata  <= load_data;
      out_tkeep  <= load_keep;
      out_tlast  <= load_last;
      out_tvalid <= 1'b1;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsizing.sv
// Bench for upsizing: directed literal cases plus randomized packets and a
// downsizer-fed loopback, all checked against a beat-pairing model.
module tb_upsizing;
  localparam int W  = 32;
  localparam int WW = 2 * W + 3;

  logic           aclk;
  logic           aresetn;
  logic [W-1:0]   in_tdata;
  logic           in_tvalid;
  logic           in_tlast;
  logic           in_tready;
  logic [2*W-1:0] out_tdata;
  logic [1:0]     out_tkeep;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready;

  upsizing #(.W(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected expected event at %0t", name, $time);
  endtask

  // scoreboard: model pairs accepted beats into expected words {data,keep,last}
  logic [WW-1:0] exp_q[$];
  logic [W-1:0]  m_hi;
  logic          m_has;
  logic          prev_stall;
  logic [WW-1:0] prev_word;
  logic [WW-1:0] cur;

  always @(negedge aclk) begin
    cur = {out_tdata, out_tkeep, out_tlast};
    if (!aresetn) begin
      exp_q.delete();
      m_has = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", WW'(out_tvalid), WW'(1));
        check("stall_word", cur, prev_word);
      end
      if (out_tvalid && out_tready) begin
        n_out++;
        if (exp_q.size() == 0) fail("unexpected_word");
        else check("out_word", cur, exp_q.pop_front());
      end
      prev_stall = out_tvalid && !out_tready;
      prev_word  = cur;
      if (in_tvalid && in_tready) begin
        if (!m_has) begin
          if (in_tlast) exp_q.push_back({in_tdata, {W{1'b0}}, 2'b10, 1'b1});
          else begin
            m_hi  = in_tdata;
            m_has = 1'b1;
          end
        end else begin
          exp_q.push_back({m_hi, in_tdata, 2'b11, in_tlast});
          m_has = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, output int waited);
    waited    = 0;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = l;
    forever begin
      @(negedge aclk);
      if (in_tready) break;
      waited++;
      if (waited > 200) begin
        fail("send_timeout");
        break;
      end
    end
    step();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_tready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    step();
  endtask

  task automatic check_out(input string name, input logic [2*W-1:0] d, input logic [1:0] k, input logic l);
    check({name, "_valid"}, WW'(out_tvalid), WW'(1));
    check(name, {out_tdata, out_tkeep, out_tlast}, {d, k, l});
  endtask

  logic    drv_done;
  int      w;
  int      n0;
  logic [W-1:0] b [4];

  initial begin
    aresetn = 1'b0; in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b1;
    drv_done = 1'b0;
    #1;
    check("reset_out", {out_tdata, out_tkeep, out_tlast}, '0);
    check("reset_valid", WW'(out_tvalid), WW'(0));
    check("reset_in_tready", WW'(in_tready), WW'(1));
    #20 aresetn = 1'b1;
    step();

    // basic pair with tlast
    send(32'h11111111, 1'b0, w);
    check("a0_no_out", WW'(out_tvalid), WW'(0));
    send(32'h22222222, 1'b1, w);
    check_out("pair_a", 64'h11111111_22222222, 2'b11, 1'b1);
    step();
    check("pair_a_gone", WW'(out_tvalid), WW'(0));

    // continuous 8-beat packet
    n0 = n_out;
    for (int i = 1; i <= 8; i++) begin
      send(W'(i), i == 8, w);
      check("stream_no_wait", WW'(w), WW'(0));
      if (i % 2 == 0) check_out("stream_word", {W'(i - 1), W'(i)}, 2'b11, i == 8);
    end
    drain();
    check("stream_count", WW'(n_out - n0), WW'(4));

    // odd packet with flush, then next packet
    send(32'hA, 1'b0, w);
    send(32'hB, 1'b0, w);
    check_out("odd_ab", {32'hA, 32'hB}, 2'b11, 1'b0);
    send(32'hC, 1'b1, w);
    check("flush_in_tready", WW'(in_tready), WW'(0));
    check("flush_no_out", WW'(out_tvalid), WW'(0));
    step();
    check_out("odd_c0", {32'hC, 32'h0}, 2'b10, 1'b1);
    check("after_flush_ready", WW'(in_tready), WW'(1));
    send(32'hD, 1'b0, w);
    send(32'hE, 1'b1, w);
    check_out("next_de", {32'hD, 32'hE}, 2'b11, 1'b1);
    drain();

    // backpressure
    for (int i = 0; i < 4; i++) b[i] = $urandom;
    n0 = n_out;
    out_tready = 1'b0;
    send(b[0], 1'b0, w);
    send(b[1], 1'b0, w);
    send(b[2], 1'b0, w);
    check("bp_b2_no_wait", WW'(w), WW'(0));
    fork
      send(b[3], 1'b1, w);
      begin
        repeat (2) begin
          @(negedge aclk);
          check("bp_blocked", WW'(in_tready), WW'(0));
          check_out("bp_hold", {b[0], b[1]}, 2'b11, 1'b0);
        end
        step();
        out_tready = 1'b1;
      end
    join
    drain();
    check("bp_count", WW'(n_out - n0), WW'(2));

    // async reset while HALF with a pending output
    out_tready = 1'b0;
    send(32'h1234, 1'b0, w);
    send(32'h5678, 1'b0, w);
    send(32'h9ABC, 1'b0, w);
    check_out("pre_reset", {32'h1234, 32'h5678}, 2'b11, 1'b0);
    #3 aresetn = 1'b0;
    #1;
    check("async_out", {out_tdata, out_tkeep, out_tlast}, '0);
    check("async_valid", WW'(out_tvalid), WW'(0));
    check("async_in_tready", WW'(in_tready), WW'(1));
    @(posedge aclk);
    #3 aresetn = 1'b1;
    out_tready = 1'b1;
    step();
    send(32'hCAFE0000, 1'b0, w);
    send(32'h0000BEEF, 1'b1, w);
    check_out("post_reset", {32'hCAFE0000, 32'h0000BEEF}, 2'b11, 1'b1);
    drain();

    // random packets of 1..5 beats with random valid gaps and random ready
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send($urandom, i == len - 1, w);
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          step();
          out_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // loopback: a downsizer model splits 2W-bit words, upper half first
    drv_done = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int p = 0; p < 12; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++) begin
            logic [2*W-1:0] word;
            word = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) step();
            send(word[2*W-1:W], 1'b0, w);
            repeat ($urandom_range(0, 1)) step();
            send(word[W-1:0], i == len - 1, w);
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          step();
          out_tready = ($urandom_range(0, 1) != 0);
        end
      end
    join
    drain();
    check("loop_all_drained", WW'(exp_q.size()), WW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/upsizing.md
Name: upsizing

Overview:
- AXI-Stream width upsizer: packs pairs of W-bit input beats into one 2W-bit output beat.
- Sits directly downstream of the 2W-to-W downsizer and is its inverse. Half ordering matches the downsizer: the first beat goes to the upper half and the second to the lower half. A downsizer→upsizer chain is therefore data-transparent.
- Also handles tlast on an odd beat by emitting a half-filled word, flagged through tkeep.

Parameters:
- W, default 32, input beat width; output width is 2*W.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low; clears all state.
- in_tdata  in  W  input beat data.
- in_tvalid  in  1  input beat valid.
- in_tlast  in  1  last beat of packet.
- in_tready  out  1  input ready (combinational).
- out_tdata  out  2W  packed word; [2W-1:W] = first beat, [W-1:0] = second beat.
- out_tkeep  out  2  half-valid flags; bit1 = upper half, bit0 = lower half.
- out_tlast  out  1  packet end.
- out_tvalid  out  1  output valid (registered).
- out_tready  in  1  output ready.

Behaviour:
- State registers:
  - hold register hi_q[W]
  - half_valid: hold register occupied
  - half_last: held beat carried tlast
  - output register: out_tdata, out_tkeep, out_tlast, out_tvalid
- Reset (aresetn=0, async): out_tvalid=0, out_tdata=0, out_tkeep=2'b00, out_tlast=0, half_valid=0, half_last=0, hi_q=0.
- out_free = ~out_tvalid | out_tready.
- in_tready = ~half_valid | (~half_last & out_free).
  - Never depends on in_tvalid or in_tlast.
  - A combinational path from out_tready is permitted.
- Input accept: in_fire = in_tvalid & in_tready.
- States: EMPTY (half_valid=0), HALF (half_valid=1, half_last=0), FLUSH (half_valid=1, half_last=1).
- EMPTY, on in_fire:
  - hi_q<=in_tdata, half_valid<=1, half_last<=in_tlast.
  - Next state is HALF, or FLUSH if in_tlast=1.
  - The output register is not loaded.
- HALF, on in_fire (requires out_free):
  - out_tdata<={hi_q,in_tdata}, out_tkeep<=2'b11, out_tlast<=in_tlast, out_tvalid<=1.
  - half_valid<=0, giving EMPTY.
- HALF, output stalled (~out_free): in_tready=0; hold hi_q.
- FLUSH: in_tready=0. When out_free:
  - out_tdata<={hi_q,{W{1'b0}}}, out_tkeep<=2'b10, out_tlast<=1, out_tvalid<=1.
  - half_valid<=0, half_last<=0, giving EMPTY.
  - Costs exactly one cycle with no input accepted.
- Output register:
  - If no load occurs this cycle and out_tready=1: out_tvalid<=0.
  - If out_tvalid & ~out_tready: out_tdata/keep/last/valid hold stable (AXI rule).
  - Load and drain in the same cycle are legal: the new word replaces the drained one and out_tvalid stays 1.
- Latency: output word valid in the cycle after the second beat (or the flush) is accepted.
- Throughput: with out_tready held at 1, one input beat per cycle is sustained, giving one output per two cycles.
- Packet boundaries: a packet never shares an output word with the next one. After tlast the pairing restarts in EMPTY.
- Reset mid-operation:
  - A held half beat is discarded.
  - A pending output is dropped.
  - in_tready is 1 after reset release (EMPTY).

Test Plan:
- Beats A0=0x11111111, A1=0x22222222 (A1 with tlast), out_tready=1 → one output 0x11111111_22222222, keep=11, last=1, valid one cycle after A1 accepted.
- Continuous 8-beat packet 1..8 (last on 8), out_tready=1 → in_tready stays 1; outputs {1,2},{3,4},{5,6},{7,8}, keep=11 each, last only on {7,8}; one output every 2 cycles.
- Odd packet: 3 beats 0xA,0xB,0xC (last on 0xC) → outputs {A,B} keep=11 last=0; then {C,0} keep=10 last=1. in_tready=0 for exactly the flush cycle; the next packet's first beat is placed in the upper half.
- Backpressure: out_tready=0 for 5 cycles while 4 beats are offered → first word held stable; third beat accepted into hold; fourth beat blocked (in_tready=0). After release, words {b0,b1},{b2,b3} arrive in order with no loss or duplication.
- Reset asserted asynchronously while in HALF and with out_tvalid=1 → out_tvalid, out_tkeep, out_tlast, out_tdata read 0 immediately, without waiting for a clock edge; after release, in_tready=1 and a new pair packs from the upper half.
- Loopback: the 2W→W downsizer feeds this block, with random 64-bit words and random valid/ready → output data equals the downsizer input sequence, keep=11 on every word.
